// File: rtl/iq_integrator_if.sv
// rtl/iq_integrator_if.sv - sample-in / result-out bundle for iq_integrator
//   clear, sample, sample_valid : restart and ADC sample stream (no backpressure)
//   x_out, y_out, out_valid     : signed 10-bit I/Q result and its valid flag
//   out_ready                   : consumer accepts the result when out_valid && out_ready
//   overrun                     : sticky, an unconsumed result was overwritten
interface iq_integrator_if #(
  parameter int SAMPLE_W = 12
);
  logic                       clear;
  logic signed [SAMPLE_W-1:0] sample;
  logic                       sample_valid;
  logic signed [9:0]          x_out;
  logic signed [9:0]          y_out;
  logic                       out_valid;
  logic                       out_ready;
  logic                       overrun;

  modport master (
    output clear, sample, sample_valid, out_ready,
    input  x_out, y_out, out_valid, overrun
  );

  modport slave (
    input  clear, sample, sample_valid, out_ready,
    output x_out, y_out, out_valid, overrun
  );
endinterface

// File: rtl/iq_integrator.sv
// rtl/iq_integrator.sv - fs/4 quadrature mix, integrate-and-dump, scale and saturate
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : iq_integrator_if.slave (sample stream in, x/y result out, overrun flag)
//   Optional macro IQ_ROUND_EN: round half-up before the shift instead of truncating.
module iq_integrator #(
  parameter int SAMPLE_W     = 12,
  parameter int ACC_LEN_LOG2 = 6,
  parameter int SHIFT        = 7
) (
  input  logic          clk,
  input  logic          rst,
  iq_integrator_if.slave bus
);
  localparam int ACC_W = SAMPLE_W + ACC_LEN_LOG2;
  localparam logic signed [ACC_W:0] SAT_MAX = (ACC_W+1)'(511);
  localparam logic signed [ACC_W:0] SAT_MIN = -SAT_MAX;
`ifdef IQ_ROUND_EN
  localparam logic signed [ACC_W:0] RND = (ACC_W+1)'(1) <<< (SHIFT - 1);
`endif

  logic signed [ACC_W-1:0]  acc_i, acc_q;
  logic signed [ACC_W-1:0]  s_ext, sum_i, sum_q;
  logic [ACC_LEN_LOG2-1:0]  count;
  logic [1:0]               phase;
  logic                     last;

  // Sum is widened by one bit so the rounding add cannot wrap; the clamp is
  // symmetric so -512 never leaves this block.
  function automatic logic signed [9:0] scale(input logic signed [ACC_W-1:0] s);
    logic signed [ACC_W:0] w;
    w = {s[ACC_W-1], s};
`ifdef IQ_ROUND_EN
    w = w + RND;
`endif
    w = w >>> SHIFT;
    if (w > SAT_MAX)      scale = 10'sd511;
    else if (w < SAT_MIN) scale = -10'sd511;
    else                  scale = w[9:0];
  endfunction

  assign s_ext = {{ACC_LEN_LOG2{bus.sample[SAMPLE_W-1]}}, bus.sample};
  assign last  = &count;

  // LO: cos = +1,0,-1,0 feeds I ; -sin = 0,-1,0,+1 feeds Q
  always_comb begin
    sum_i = acc_i;
    sum_q = acc_q;
    case (phase)
      2'd0:    sum_i = acc_i + s_ext;
      2'd1:    sum_q = acc_q - s_ext;
      2'd2:    sum_i = acc_i - s_ext;
      default: sum_q = acc_q + s_ext;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_i         <= '0;
      acc_q         <= '0;
      count         <= '0;
      phase         <= '0;
      bus.x_out     <= '0;
      bus.y_out     <= '0;
      bus.out_valid <= 1'b0;
      bus.overrun   <= 1'b0;
    end else if (bus.clear) begin
      // x/y deliberately keep their last values
      acc_i         <= '0;
      acc_q         <= '0;
      count         <= '0;
      phase         <= '0;
      bus.out_valid <= 1'b0;
      bus.overrun   <= 1'b0;
    end else begin
      if (bus.out_valid && bus.out_ready)
        bus.out_valid <= 1'b0;
      if (bus.sample_valid) begin
        // phase is never reset at a dump; ACC_LEN is a multiple of 4 so it stays aligned
        phase <= phase + 2'd1;
        count <= count + ACC_LEN_LOG2'(1);
        if (last) begin
          bus.x_out     <= scale(sum_i);
          bus.y_out     <= scale(sum_q);
          bus.out_valid <= 1'b1;
          if (bus.out_valid && !bus.out_ready)
            bus.overrun <= 1'b1;
          acc_i <= '0;
          acc_q <= '0;
        end else begin
          acc_i <= sum_i;
          acc_q <= sum_q;
        end
      end
    end
  end
endmodule

// File: tb/tb_iq_integrator.sv
// tb/tb_iq_integrator.sv - self-checking bench for iq_integrator
module tb_iq_integrator;
  localparam int SAMPLE_W = 12;
  localparam int LOG2     = 6;
  localparam int SHIFT    = 7;
  localparam int N        = 1 << LOG2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  iq_integrator_if #(.SAMPLE_W(SAMPLE_W)) bus ();

  iq_integrator #(
    .SAMPLE_W(SAMPLE_W), .ACC_LEN_LOG2(LOG2), .SHIFT(SHIFT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // reference model state
  int win[$];
  int m_x, m_y;
  bit m_valid, m_ovr;
  int lo_i[4] = '{1, 0, -1, 0};
  int lo_q[4] = '{0, -1, 0, 1};

  function automatic int scale_ref(input int sum);
    int v;
`ifdef IQ_ROUND_EN
    v = (sum + (1 << (SHIFT - 1))) >>> SHIFT;
`else
    v = sum >>> SHIFT;
`endif
    if (v > 511)  v = 511;
    if (v < -511) v = -511;
    return v;
  endfunction

  task automatic model_reset();
    win.delete();
    m_valid = 0;
    m_ovr   = 0;
    m_x     = 0;
    m_y     = 0;
  endtask

  // One clock: drive a sample (or none), take the edge, advance the model.
  task automatic tick(input bit v, input int s);
    int si, sq;
    bit dump;
    bus.sample_valid = v;
    bus.sample       = SAMPLE_W'(s);
    @(posedge clk);
    dump = 0;
    if (bus.clear) begin
      win.delete();
      m_valid = 0;
      m_ovr   = 0;
    end else begin
      if (v) begin
        win.push_back(s);
        if (win.size() == N) begin
          si = 0;
          sq = 0;
          foreach (win[k]) begin
            si += win[k] * lo_i[k % 4];
            sq += win[k] * lo_q[k % 4];
          end
          win.delete();
          dump = 1;
          if (m_valid && !bus.out_ready) m_ovr = 1;
          m_valid = 1;
          m_x = scale_ref(si);
          m_y = scale_ref(sq);
        end
      end
      if (!dump && m_valid && bus.out_ready) m_valid = 0;
    end
    #1;
    bus.sample_valid = 1'b0;
  endtask

  task automatic consume();
    bus.out_ready = 1'b1;
    tick(0, 0);
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.clear = 1'b0;
    bus.out_ready = 1'b0;
    bus.sample_valid = 1'b0;
    bus.sample = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.x_out !== 10'd0) begin failures++; $display("FAIL reset_x got=%0d exp=0", $signed(bus.x_out)); end
    checks++; if (bus.y_out !== 10'd0) begin failures++; $display("FAIL reset_y got=%0d exp=0", $signed(bus.y_out)); end
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", bus.out_valid); end
    checks++; if (bus.overrun !== 1'b0) begin failures++; $display("FAIL reset_overrun got=%b exp=0", bus.overrun); end
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_cosine();
    int p[4] = '{1000, 0, -1000, 0};
    for (int k = 0; k < N; k++) begin
      tick(1, p[k % 4]);
      if (k == N - 2) begin
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL cos_early_valid got=%b exp=0", bus.out_valid); end
      end
    end
    checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL cos_valid got=%b exp=1", bus.out_valid); end
    checks++; if (bus.x_out !== 10'sd250) begin failures++; $display("FAIL cos_x got=%0d exp=250", $signed(bus.x_out)); end
    checks++; if (bus.y_out !== 10'sd0) begin failures++; $display("FAIL cos_y got=%0d exp=0", $signed(bus.y_out)); end
    consume();
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL cos_consume got=%b exp=0", bus.out_valid); end
  endtask

  task automatic test_sine_dc();
    int p[4] = '{0, 1000, 0, -1000};
    for (int k = 0; k < N; k++) tick(1, p[k % 4]);
    checks++; if (bus.x_out !== 10'sd0) begin failures++; $display("FAIL sin_x got=%0d exp=0", $signed(bus.x_out)); end
    checks++; if (bus.y_out !== -10'sd250) begin failures++; $display("FAIL sin_y got=%0d exp=-250", $signed(bus.y_out)); end
    consume();
    for (int k = 0; k < N; k++) tick(1, 100);
    checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL dc_valid got=%b exp=1", bus.out_valid); end
    checks++; if (bus.x_out !== 10'sd0) begin failures++; $display("FAIL dc_x got=%0d exp=0", $signed(bus.x_out)); end
    checks++; if (bus.y_out !== 10'sd0) begin failures++; $display("FAIL dc_y got=%0d exp=0", $signed(bus.y_out)); end
    consume();
  endtask

  task automatic test_saturation();
    int pp[4] = '{2047, 0, -2048, 0};
    int pn[4] = '{-2048, 0, 2047, 0};
    for (int k = 0; k < N; k++) tick(1, pp[k % 4]);
    checks++; if (bus.x_out !== 10'sd511) begin failures++; $display("FAIL sat_pos_x got=%0d exp=511", $signed(bus.x_out)); end
    consume();
    for (int k = 0; k < N; k++) tick(1, pn[k % 4]);
    checks++; if (bus.x_out !== -10'sd511) begin failures++; $display("FAIL sat_neg_x got=%0d exp=-511", $signed(bus.x_out)); end
    checks++; if (bus.y_out !== 10'sd0) begin failures++; $display("FAIL sat_neg_y got=%0d exp=0", $signed(bus.y_out)); end
    consume();
  endtask

  task automatic test_rounding();
    int p[4] = '{6, 0, 0, 0};
    logic signed [9:0] exp_x;
`ifdef IQ_ROUND_EN
    exp_x = 10'sd1;
`else
    exp_x = 10'sd0;
`endif
    for (int k = 0; k < N; k++) tick(1, p[k % 4]);
    checks++; if (bus.x_out !== exp_x) begin failures++; $display("FAIL round_x got=%0d exp=%0d", $signed(bus.x_out), exp_x); end
    consume();
  endtask

  task automatic test_overrun();
    int first_x;
    bus.out_ready = 1'b0;
    for (int k = 0; k < N; k++) tick(1, int'($urandom_range(0, 4095)) - 2048);
    first_x = m_x;
    checks++; if (bus.out_valid !== 1'b1 || bus.overrun !== 1'b0) begin failures++; $display("FAIL ovr_first got=%b%b exp=10", bus.out_valid, bus.overrun); end
    for (int k = 0; k < N; k++) begin
      tick(1, int'($urandom_range(0, 4095)) - 2048);
      if (k == N / 2) begin
        checks++; if (bus.x_out !== 10'(first_x)) begin failures++; $display("FAIL ovr_hold_x got=%0d exp=%0d", $signed(bus.x_out), first_x); end
      end
    end
    checks++; if (bus.overrun !== 1'b1) begin failures++; $display("FAIL ovr_flag got=%b exp=1", bus.overrun); end
    checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL ovr_valid got=%b exp=1", bus.out_valid); end
    checks++; if (bus.x_out !== 10'(m_x) || bus.y_out !== 10'(m_y)) begin failures++; $display("FAIL ovr_xy got=%0d,%0d exp=%0d,%0d", $signed(bus.x_out), $signed(bus.y_out), m_x, m_y); end
    bus.clear = 1'b1;
    tick(0, 0);
    bus.clear = 1'b0;
    checks++; if (bus.overrun !== 1'b0 || bus.out_valid !== 1'b0) begin failures++; $display("FAIL clr_flags got=%b%b exp=00", bus.out_valid, bus.overrun); end
    checks++; if (bus.x_out !== 10'(m_x)) begin failures++; $display("FAIL clr_keep_x got=%0d exp=%0d", $signed(bus.x_out), m_x); end
    for (int k = 0; k < N; k++) tick(1, int'($urandom_range(0, 4095)) - 2048);
    for (int k = 0; k < N; k++) begin
      bus.out_ready = (k == N - 1);
      tick(1, int'($urandom_range(0, 4095)) - 2048);
    end
    bus.out_ready = 1'b0;
    checks++; if (bus.overrun !== 1'b0 || bus.out_valid !== 1'b1) begin failures++; $display("FAIL ready_on_dump got=%b%b exp=10", bus.out_valid, bus.overrun); end
    checks++; if (bus.x_out !== 10'(m_x) || bus.y_out !== 10'(m_y)) begin failures++; $display("FAIL ready_on_dump_xy got=%0d,%0d exp=%0d,%0d", $signed(bus.x_out), $signed(bus.y_out), m_x, m_y); end
    consume();
  endtask

  task automatic test_reset_mid();
    int p[4] = '{1000, 0, -1000, 0};
    for (int k = 0; k < 30; k++) tick(1, p[k % 4]);
    #2 rst = 1'b1;
    #1;
    checks++; if (bus.x_out !== 10'd0 || bus.y_out !== 10'd0) begin failures++; $display("FAIL async_rst_xy got=%0d,%0d exp=0,0", $signed(bus.x_out), $signed(bus.y_out)); end
    checks++; if (bus.out_valid !== 1'b0 || bus.overrun !== 1'b0) begin failures++; $display("FAIL async_rst_flags got=%b%b exp=00", bus.out_valid, bus.overrun); end
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    for (int k = 0; k < N; k++) tick(1, p[k % 4]);
    checks++; if (bus.x_out !== 10'sd250 || bus.out_valid !== 1'b1) begin failures++; $display("FAIL rst_mid_window got=%0d/%b exp=250/1", $signed(bus.x_out), bus.out_valid); end
    consume();
  endtask

  task automatic test_clear_coincident();
    int p[4] = '{1000, 0, -1000, 0};
    for (int k = 0; k < 10; k++) tick(1, p[k % 4]);
    bus.clear = 1'b1;
    tick(1, 2047);
    bus.clear = 1'b0;
    for (int k = 0; k < N; k++) begin
      tick(1, p[k % 4]);
      if (k == N - 2) begin
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL clr_coinc_early got=%b exp=0", bus.out_valid); end
      end
    end
    checks++; if (bus.x_out !== 10'sd250 || bus.y_out !== 10'sd0) begin failures++; $display("FAIL clr_coinc_xy got=%0d,%0d exp=250,0", $signed(bus.x_out), $signed(bus.y_out)); end
    consume();
  endtask

  task automatic test_random();
    bit v;
    for (int c = 0; c < 4000; c++) begin
      v = ($urandom_range(0, 3) != 0);
      bus.out_ready = 1'($urandom_range(0, 1));
      bus.clear = ($urandom_range(0, 299) == 0);
      tick(v, int'($urandom_range(0, 4095)) - 2048);
      bus.clear = 1'b0;
      checks++; if (bus.out_valid !== m_valid) begin failures++; $display("FAIL rnd_valid c=%0d got=%b exp=%b", c, bus.out_valid, m_valid); end
      checks++; if (bus.overrun !== m_ovr) begin failures++; $display("FAIL rnd_overrun c=%0d got=%b exp=%b", c, bus.overrun, m_ovr); end
      if (m_valid) begin
        checks++; if (bus.x_out !== 10'(m_x) || bus.y_out !== 10'(m_y)) begin failures++; $display("FAIL rnd_xy c=%0d got=%0d,%0d exp=%0d,%0d", c, $signed(bus.x_out), $signed(bus.y_out), m_x, m_y); end
      end
    end
    bus.out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_cosine();
    test_sine_dc();
    test_saturation();
    test_rounding();
    test_overrun();
    test_reset_mid();
    test_clear_coincident();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
